// File: rtl/regf_bus_init.sv
`default_nettype none
// ============================================================================
// Module      : regf_bus_init
// Description : Bus initiator for the regf memory-slave interface. Accepts
//               single or burst read/write commands, streams write data into
//               single-cycle mem accesses and returns read data / write status
//               through a one-entry response register. Counts errored beats.
// Revision    : 1.0 - initial release
// ============================================================================
module regf_bus_init #(
  parameter int addrwidth_p   = 13,
  parameter int datawidth_p   = 32,
  parameter int lenwidth_p    = 4,
  parameter int errcntwidth_p = 8
) (
  input  logic                     main_clk_i,
  input  logic                     main_rst_an_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [addrwidth_p-1:0]   cmd_addr_i,
  input  logic [lenwidth_p-1:0]    cmd_len_i,
  input  logic                     wdat_valid_i,
  output logic                     wdat_ready_o,
  input  logic [datawidth_p-1:0]   wdat_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [datawidth_p-1:0]   rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     rsp_last_o,
  output logic                     mem_ena_o,
  output logic [addrwidth_p-1:0]   mem_addr_o,
  output logic                     mem_wena_o,
  output logic [datawidth_p-1:0]   mem_wdata_o,
  input  logic [datawidth_p-1:0]   mem_rdata_i,
  input  logic                     mem_err_i,
  output logic [errcntwidth_p-1:0] errcnt_o,
  input  logic                     errcnt_clr_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WRESP  = 3'd2,
    RD     = 3'd3,
    RDRAIN = 3'd4
  } state_t;

  localparam logic [errcntwidth_p-1:0] c_errcnt_max = '1;
  localparam logic [addrwidth_p-1:0]   c_addr_step  = addrwidth_p'(4);
  localparam logic [lenwidth_p-1:0]    c_cnt_one    = lenwidth_p'(1);

  state_t                   state_q,     state_d;
  logic [addrwidth_p-1:0]   addr_q,      addr_d;
  logic [lenwidth_p-1:0]    cnt_q,       cnt_d;
  logic                     werr_q,      werr_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [datawidth_p-1:0]   rsp_data_q,  rsp_data_d;
  logic                     rsp_err_q,   rsp_err_d;
  logic                     rsp_last_q,  rsp_last_d;
  logic [errcntwidth_p-1:0] errcnt_q,    errcnt_d;

  logic w_rsp_free;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_mem_ena;
  logic w_unused_addr_lsb;

  // Byte-offset bits of the command address are forced to zero, never used.
  assign w_unused_addr_lsb = ^cmd_addr_i[1:0];

  // Beat-fire conditions and the combinational mem strobe derived from state.
  always_comb begin
    w_rsp_free = !rsp_valid_q || rsp_ready_i;
    w_wr_fire  = (state_q == WR) && wdat_valid_i;
    w_rd_fire  = (state_q == RD) && w_rsp_free;
    w_mem_ena  = w_wr_fire || w_rd_fire;
  end

  // Port drive: mem address/data are zeroed whenever no access is made.
  always_comb begin
    cmd_ready_o  = (state_q == IDLE);
    wdat_ready_o = (state_q == WR);
    mem_ena_o    = w_mem_ena;
    mem_wena_o   = w_wr_fire;
    mem_addr_o   = w_mem_ena ? addr_q : '0;
    mem_wdata_o  = w_wr_fire ? wdat_i : '0;
    rsp_valid_o  = rsp_valid_q;
    rsp_data_o   = rsp_data_q;
    rsp_err_o    = rsp_err_q;
    rsp_last_o   = rsp_last_q;
    errcnt_o     = errcnt_q;
  end

  // Next-state for the FSM, burst bookkeeping and the response register.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    werr_d      = werr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;

    // A consumed response frees the register unless a new beat reloads it.
    if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = {cmd_addr_i[addrwidth_p-1:2], 2'b00};
          cnt_d   = cmd_len_i;
          werr_d  = 1'b0;
          state_d = cmd_write_i ? WR : RD;
        end
      end
      WR: begin
        if (w_wr_fire) begin
          werr_d = werr_q | mem_err_i;
          addr_d = addr_q + c_addr_step;
          cnt_d  = cnt_q - c_cnt_one;
          if (cnt_q == '0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = werr_q | mem_err_i;
            rsp_last_d  = 1'b1;
            state_d     = WRESP;
          end
        end
      end
      WRESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (w_rd_fire) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_rdata_i;
          rsp_err_d   = mem_err_i;
          rsp_last_d  = (cnt_q == '0);
          addr_d      = addr_q + c_addr_step;
          cnt_d       = cnt_q - c_cnt_one;
          if (cnt_q == '0) begin
            state_d = RDRAIN;
          end
        end
      end
      RDRAIN: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating error counter; clear wins over increment.
  always_comb begin
    errcnt_d = errcnt_q;
    if (errcnt_clr_i) begin
      errcnt_d = '0;
    end else if (w_mem_ena && mem_err_i && (errcnt_q != c_errcnt_max)) begin
      errcnt_d = errcnt_q + 1'b1;
    end
  end

  // State registers; reset drops any burst in flight without a response.
  always_ff @(posedge main_clk_i or posedge main_rst_an_i) begin
    if (main_rst_an_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      werr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      werr_q      <= werr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      errcnt_q    <= errcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regf_bus_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_regf_bus_init
// Description : Self-checking bench for regf_bus_init with a combinational
//               slave model (rdata = 0xCAFE0000 + word index).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regf_bus_init;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [12:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdat_valid;
  logic        wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        mem_ena;
  logic [12:0] mem_addr;
  logic        mem_wena;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [7:0]  errcnt;
  logic        errcnt_clr;

  logic        err_all;
  logic        err_addr_en;
  logic [12:0] err_addr;

  int checks   = 0;
  int failures = 0;

  regf_bus_init dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .wdat_valid_i  (wdat_valid),
    .wdat_ready_o  (wdat_ready),
    .wdat_i        (wdat),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_err_o     (rsp_err),
    .rsp_last_o    (rsp_last),
    .mem_ena_o     (mem_ena),
    .mem_addr_o    (mem_addr),
    .mem_wena_o    (mem_wena),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_err_i     (mem_err),
    .errcnt_o      (errcnt),
    .errcnt_clr_i  (errcnt_clr)
  );

  // Slave model: same-cycle response, error either global or on one address.
  assign mem_rdata = 32'hCAFE0000 + 32'(mem_addr >> 2);
  assign mem_err   = err_all | (err_addr_en & mem_ena & (mem_addr == err_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] a;
    logic        we;
    logic [31:0] wd;
  } acc_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        l;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  // Log accesses and consumed responses mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (mem_ena) acc_q.push_back('{a: mem_addr, we: mem_wena, wd: mem_wdata});
    if (rsp_valid && rsp_ready) rsp_q.push_back('{d: rsp_data, e: rsp_err, l: rsp_last});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one command with rsp_ready held high; writes stream wbase+i.
  task automatic xfer(input logic wr, input logic [12:0] a, input logic [3:0] len,
                      input logic [31:0] wbase);
    bit done;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    if (wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        wdat_valid = 1'b1;
        wdat = wbase + 32'(i);
        tick();
      end
      wdat_valid = 1'b0;
      wdat = '0;
    end
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (cmd_ready && !rsp_valid) done = 1'b1;
      else tick();
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [12:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] held;

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wdat_valid = 0; wdat = '0; rsp_ready = 1'b1; errcnt_clr = 0;
    err_all = 0; err_addr_en = 0; err_addr = '0;

    vecs[0] = '{wr: 0, addr: 13'h0004, wd: 32'h0, err: 0, exp_addr: 13'h0004, exp_data: 32'hCAFE0001, exp_err: 0};
    vecs[1] = '{wr: 0, addr: 13'h0013, wd: 32'h0, err: 0, exp_addr: 13'h0010, exp_data: 32'hCAFE0004, exp_err: 0};
    vecs[2] = '{wr: 1, addr: 13'h0020, wd: 32'hDEADBEEF, err: 0, exp_addr: 13'h0020, exp_data: 32'h0, exp_err: 0};
    vecs[3] = '{wr: 0, addr: 13'h1FFC, wd: 32'h0, err: 1, exp_addr: 13'h1FFC, exp_data: 32'hCAFE07FF, exp_err: 1};
    vecs[4] = '{wr: 1, addr: 13'h0101, wd: 32'h12345678, err: 1, exp_addr: 13'h0100, exp_data: 32'h0, exp_err: 1};

    // Reset state
    tick(); tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_rsp_last",  32'(rsp_last), 32'd0);
    chk("rst_errcnt",    32'(errcnt), 32'd0);
    chk("rst_mem_ena",   32'(mem_ena), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Test 1: single read, cycle-exact latency
    cmd_valid = 1; cmd_write = 0; cmd_addr = 13'h0004; cmd_len = 0;
    #1;
    chk("t1_c0_ready", 32'(cmd_ready), 32'd1);
    chk("t1_c0_ena",   32'(mem_ena), 32'd0);
    tick(); cmd_valid = 0; #1;
    chk("t1_c1_ena",   32'(mem_ena), 32'd1);
    chk("t1_c1_addr",  32'(mem_addr), 32'h0004);
    chk("t1_c1_wena",  32'(mem_wena), 32'd0);
    chk("t1_c1_valid", 32'(rsp_valid), 32'd0);
    tick(); #1;
    chk("t1_c2_ena",   32'(mem_ena), 32'd0);
    chk("t1_c2_valid", 32'(rsp_valid), 32'd1);
    chk("t1_c2_data",  rsp_data, 32'hCAFE0001);
    chk("t1_c2_err",   32'(rsp_err), 32'd0);
    chk("t1_c2_last",  32'(rsp_last), 32'd1);
    tick(); #1;
    chk("t1_c3_ready", 32'(cmd_ready), 32'd1);
    chk("t1_c3_valid", 32'(rsp_valid), 32'd0);

    // Table-driven single-beat transactions
    for (int i = 0; i < 5; i++) begin
      acc_q.delete(); rsp_q.delete();
      err_addr_en = vecs[i].err; err_addr = vecs[i].exp_addr;
      xfer(vecs[i].wr, vecs[i].addr, 4'd0, vecs[i].wd);
      err_addr_en = 0;
      chk($sformatf("v%0d_nacc", i), 32'(acc_q.size()), 32'd1);
      chk($sformatf("v%0d_nrsp", i), 32'(rsp_q.size()), 32'd1);
      if (acc_q.size() == 1) begin
        chk($sformatf("v%0d_addr", i), 32'(acc_q[0].a), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_wena", i), 32'(acc_q[0].we), 32'(vecs[i].wr));
        chk($sformatf("v%0d_wdata", i), acc_q[0].wd, vecs[i].wr ? vecs[i].wd : 32'h0);
      end
      if (rsp_q.size() == 1) begin
        chk($sformatf("v%0d_rdata", i), rsp_q[0].d, vecs[i].exp_data);
        chk($sformatf("v%0d_rerr", i), 32'(rsp_q[0].e), 32'(vecs[i].exp_err));
        chk($sformatf("v%0d_rlast", i), 32'(rsp_q[0].l), 32'd1);
      end
    end
    chk("tbl_errcnt", 32'(errcnt), 32'd2);
    errcnt_clr = 1; tick(); errcnt_clr = 0; #1;
    chk("tbl_errcnt_clr", 32'(errcnt), 32'd0);

    // Test 2: write burst with a gap in write data
    acc_q.delete(); rsp_q.delete();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 13'h0000; cmd_len = 2;
    tick(); cmd_valid = 0;
    wdat_valid = 1; wdat = 32'h11; #1;
    chk("t2_b0_ena",   32'(mem_ena), 32'd1);
    chk("t2_b0_ready", 32'(wdat_ready), 32'd1);
    chk("t2_b0_addr",  32'(mem_addr), 32'h0000);
    chk("t2_b0_wdata", mem_wdata, 32'h11);
    tick(); wdat_valid = 0; wdat = 32'h99; #1;
    chk("t2_gap_ena",   32'(mem_ena), 32'd0);
    chk("t2_gap_addr",  32'(mem_addr), 32'h0);
    chk("t2_gap_wdata", mem_wdata, 32'h0);
    tick(); wdat_valid = 1; wdat = 32'h22; #1;
    chk("t2_b1_addr",  32'(mem_addr), 32'h0004);
    chk("t2_b1_wdata", mem_wdata, 32'h22);
    tick(); wdat = 32'h33; #1;
    chk("t2_b2_addr",  32'(mem_addr), 32'h0008);
    chk("t2_b2_wdata", mem_wdata, 32'h33);
    chk("t2_b2_wena",  32'(mem_wena), 32'd1);
    tick(); wdat_valid = 0; wdat = '0; #1;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_data",  rsp_data, 32'h0);
    chk("t2_rsp_err",   32'(rsp_err), 32'd0);
    chk("t2_rsp_last",  32'(rsp_last), 32'd1);
    chk("t2_wready_off", 32'(wdat_ready), 32'd0);
    tick(); #1;
    chk("t2_idle", 32'(cmd_ready), 32'd1);
    chk("t2_nacc", 32'(acc_q.size()), 32'd3);
    chk("t2_nrsp", 32'(rsp_q.size()), 32'd1);

    // Test 3: read burst with response backpressure
    acc_q.delete(); rsp_q.delete();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 13'h0010; cmd_len = 3;
    tick(); cmd_valid = 0;
    tick();
    tick(); rsp_ready = 0; #1;
    held = rsp_data;
    chk("t3_stall_data0", held, 32'hCAFE0005);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t3_stall_ena%0d", c), 32'(mem_ena), 32'd0);
      chk($sformatf("t3_stall_hold%0d", c), rsp_data, held);
      tick();
    end
    rsp_ready = 1;
    xfer_wait: for (int c = 0; c < 50; c++) begin
      #1;
      if (cmd_ready && !rsp_valid) break;
      tick();
    end
    chk("t3_nacc", 32'(acc_q.size()), 32'd4);
    chk("t3_nrsp", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_q.size() && i < rsp_q.size(); i++) begin
      chk($sformatf("t3_addr%0d", i), 32'(acc_q[i].a), 32'h10 + 32'(4 * i));
      chk($sformatf("t3_data%0d", i), rsp_q[i].d, 32'hCAFE0004 + 32'(i));
      chk($sformatf("t3_last%0d", i), 32'(rsp_q[i].l), (i == 3) ? 32'd1 : 32'd0);
    end

    // Test 4: error path on read then write
    acc_q.delete(); rsp_q.delete();
    err_addr_en = 1; err_addr = 13'h0044;
    xfer(1'b0, 13'h0040, 4'd1, 32'h0);
    err_addr = 13'h0080;
    xfer(1'b1, 13'h0080, 4'd1, 32'hA0);
    err_addr_en = 0;
    chk("t4_nrsp", 32'(rsp_q.size()), 32'd3);
    if (rsp_q.size() == 3) begin
      chk("t4_rd0_err", 32'(rsp_q[0].e), 32'd0);
      chk("t4_rd1_err", 32'(rsp_q[1].e), 32'd1);
      chk("t4_rd1_last", 32'(rsp_q[1].l), 32'd1);
      chk("t4_wr_err", 32'(rsp_q[2].e), 32'd1);
      chk("t4_wr_data", rsp_q[2].d, 32'h0);
    end
    chk("t4_errcnt", 32'(errcnt), 32'd2);
    errcnt_clr = 1; tick(); errcnt_clr = 0; #1;
    chk("t4_errcnt_clr", 32'(errcnt), 32'd0);

    // Test 5: address wrap and counter saturation
    acc_q.delete(); rsp_q.delete();
    xfer(1'b0, 13'h1FFC, 4'd1, 32'h0);
    chk("t5_nacc", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      chk("t5_addr0", 32'(acc_q[0].a), 32'h1FFC);
      chk("t5_addr1", 32'(acc_q[1].a), 32'h0000);
    end
    err_all = 1;
    for (int b = 0; b < 15; b++) xfer(1'b0, 13'h0200, 4'd15, 32'h0);
    err_all = 0; #1;
    chk("t5_errcnt240", 32'(errcnt), 32'd240);
    err_all = 1;
    for (int b = 0; b < 4; b++) xfer(1'b0, 13'h0200, 4'd15, 32'h0);
    err_all = 0; #1;
    chk("t5_errcnt_sat", 32'(errcnt), 32'd255);

    // Test 6: reset during the second beat of a 4-beat read
    acc_q.delete(); rsp_q.delete();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 13'h0020; cmd_len = 3;
    tick(); cmd_valid = 0;
    tick(); #1;
    chk("t6_beat2_ena", 32'(mem_ena), 32'd1);
    chk("t6_beat2_addr", 32'(mem_addr), 32'h0024);
    rst = 1; #1;
    chk("t6_rst_ena",   32'(mem_ena), 32'd0);
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_data",  rsp_data, 32'h0);
    chk("t6_rst_errcnt", 32'(errcnt), 32'd0);
    tick(); rst = 0; tick(); #1;
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    chk("t6_nrsp_drop", 32'(rsp_q.size()), 32'd0);
    acc_q.delete(); rsp_q.delete();
    xfer(1'b0, 13'h0008, 4'd0, 32'h0);
    chk("t6_nacc", 32'(acc_q.size()), 32'd1);
    chk("t6_nrsp", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) begin
      chk("t6_data", rsp_q[0].d, 32'hCAFE0002);
      chk("t6_last", 32'(rsp_q[0].l), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regf_bus_init.md
Name: regf_bus_init

Overview:
- Bus initiator for the regf memory-slave interface. It drives the `mem_ena/addr/wena/wdata` signals and consumes `rdata/err`.
- It takes single or burst commands over a valid/ready command port, plus a write-data stream, and returns read data and write status over a valid/ready response port.
- It sits between a host sequencer (debug or CPU bridge) and one or more regf instances.

Parameters:
- `addrwidth_p`, 13: mem byte-address width.
- `datawidth_p`, 32: mem data width.
- `lenwidth_p`, 4: burst-length field width; beats = `cmd_len_i` + 1, max 16.
- `errcntwidth_p`, 8: error-counter width.

Ports:
- `main_clk_i` — in — 1 — clock.
- `main_rst_an_i` — in — 1 — reset, asynchronous, active-high.
- `cmd_valid_i` — in — 1 — command valid.
- `cmd_ready_o` — out — 1 — command accepted when valid and ready are both high.
- `cmd_write_i` — in — 1 — 1 = write burst, 0 = read burst.
- `cmd_addr_i` — in — `addrwidth_p` — start byte address, word aligned.
- `cmd_len_i` — in — `lenwidth_p` — beats minus 1.
- `wdat_valid_i` — in — 1 — write-data beat valid.
- `wdat_ready_o` — out — 1 — write-data beat consumed.
- `wdat_i` — in — `datawidth_p` — write-data beat.
- `rsp_valid_o` — out — 1 — response valid.
- `rsp_ready_i` — in — 1 — response consumed.
- `rsp_data_o` — out — `datawidth_p` — read data; 0 for write responses.
- `rsp_err_o` — out — 1 — beat error (read) or OR of beat errors (write).
- `rsp_last_o` — out — 1 — final response of the burst.
- `mem_ena_o` — out — 1 — access strobe.
- `mem_addr_o` — out — `addrwidth_p` — access byte address.
- `mem_wena_o` — out — 1 — 1 = write access.
- `mem_wdata_o` — out — `datawidth_p` — write data.
- `mem_rdata_i` — in — `datawidth_p` — read data, valid in the same cycle as `mem_ena_o`.
- `mem_err_i` — in — 1 — access error, valid in the same cycle as `mem_ena_o`.
- `errcnt_o` — out — `errcntwidth_p` — saturating count of errored beats.
- `errcnt_clr_i` — in — 1 — synchronous clear of `errcnt_o`.

Behaviour:
- **Reset.** While `main_rst_an_i`=1 the block is in IDLE, and:
  - `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0, `rsp_last_o`=0;
  - the error counter is 0;
  - the address register, beat counter and sticky write error are all 0.
- **Reset mid-burst.** The burst is dropped, no response is produced, and `mem_ena_o` drops immediately because it is combinational from state.
- **mem protocol.** The slave responds combinationally in the same cycle; one access is one cycle with `mem_ena_o`=1. When `mem_ena_o`=0, `mem_addr_o`, `mem_wena_o` and `mem_wdata_o` are 0.
- **FSM: IDLE, WR, WRESP, RD, RDRAIN.**
- **IDLE.**
  - `cmd_ready_o`=1 (it is 0 in all other states).
  - On handshake, latch the address and the beat count (`cmd_len_i`), clear the sticky error, and go to WR or RD according to `cmd_write_i`.
  - No mem access occurs in the acceptance cycle. The first access is at the earliest in the next cycle.
- **WR.**
  - `wdat_ready_o`=1 only in WR.
  - A beat fires when `wdat_valid_i`=1. In that cycle: `mem_ena_o`=1, `mem_wena_o`=1, `mem_addr_o`=current address, `mem_wdata_o`=`wdat_i`, and `wdat_ready_o`=1. The sticky error ORs in `mem_err_i`.
  - After the beat, the address increments by 4 and the count decrements.
  - On the last beat (count = 0), load the response register (`rsp_valid_o`=1, `rsp_data_o`=0, `rsp_err_o`=sticky | `mem_err_i`, `rsp_last_o`=1) and go to WRESP.
- **WRESP.** Hold the response until `rsp_ready_i`=1, then clear `rsp_valid_o` and go to IDLE.
- **RD.**
  - A beat fires when the response register is free: `rsp_valid_o`=0, or `rsp_valid_o`=1 and `rsp_ready_i`=1 (back-to-back allowed).
  - In that cycle: `mem_ena_o`=1 and `mem_wena_o`=0. Load the response register with `mem_rdata_i` and `mem_err_i`; `rsp_last_o` = (count = 0).
  - The address increments by 4. After the last beat, go to RDRAIN.
  - If the register is occupied and not being consumed, no access is made (stall).
- **RDRAIN.** On `rsp_ready_i`=1, clear `rsp_valid_o` and go to IDLE.
- **Response register.**
  - Fields are stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
  - When no new beat loads, `rsp_valid_o` clears on handshake.
- **Address arithmetic.** Modulo 2^`addrwidth_p`; the increment wraps (e.g. 0x1FFC + 4 → 0x0000). `cmd_addr_i[1:0]` is ignored and forced to 00.
- **Errors.** An errored beat does not abort the burst.
- **Error counter.**
  - +1 per cycle in which `mem_ena_o` and `mem_err_i` are both 1; saturates at all-ones.
  - `errcnt_clr_i` has priority over increment in the same cycle.
- **Latency.**
  - Read, ready sink: command at cycle 0, first `mem_ena_o` at cycle 1, first `rsp_valid_o` at cycle 2, then one beat per cycle.
  - Write: the last beat is in cycle N, and `rsp_valid_o` is high from cycle N+1.

Test Plan:
1. Single read: cmd(addr=0x0004, len=0, write=0), slave returns 0xCAFE0001, `rsp_ready_i`=1 → `mem_ena_o` high for exactly one cycle at addr 0x0004; response data=0xCAFE0001, err=0, last=1 at cycle 2; back to IDLE at cycle 3.
2. Write burst: cmd(addr=0x0000, len=2, write=1), `wdat_valid_i` toggling 1,0,1,1 with data 0x11, 0x22, 0x33 → writes at 0x0000, 0x0004, 0x0008 with matching data; no access in the gap cycle; one response with data=0, err=0, last=1.
3. Read with backpressure: len=3 and `rsp_ready_i` low for 3 cycles after the first response → exactly 4 accesses, no lost or duplicated data; address sequence 0x10, 0x14, 0x18, 0x1C; last=1 only on the 4th response.
4. Error path: read len=1 where the slave asserts `mem_err_i` on the 2nd beat; then write len=1 with error on the 1st beat → read responses have err=0 then 1; write response err=1; `errcnt_o`=2; `errcnt_clr_i` pulse → 0.
5. Wrap-around and saturation: read at addr=0x1FFC, len=1 → accesses at 0x1FFC, then 0x0000. Force 300 errored beats → `errcnt_o`=255.
6. Reset mid-burst: assert reset during the 2nd beat of a 4-beat read → `mem_ena_o` and `rsp_valid_o` go to 0 immediately; after release, `cmd_ready_o`=1 and a new single read completes correctly.
